demux_4ch_stream: RTL and testbench

- 1-to-4 registered stream demultiplexer; the distribution-side counterpart of the 4:1 select mux used in the barrel-shifter datapath.
- Routes each accepted input word to one of four output channels using valid/ready handshakes on every port.
- The target channel comes either from an explicit select input or from an internal round-robin pointer.
- Each channel has a one-entry output register, so downstream consumers stall independently of one another.

---
 rtl/demux_4ch_stream_pkg.sv | 18 +
 rtl/demux_4ch_stream_slot.sv | 55 +++++
 rtl/demux_4ch_stream.sv | 81 ++++++++
 tb/tb_demux_4ch_stream.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_4ch_stream_pkg.sv
// Shared definitions for the 4-channel stream demultiplexer: channel count,
// select width, target-mode encodings and the slot state type.
package demux_4ch_stream_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    typedef logic [SEL_W-1:0] ch_idx_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_4ch_stream_slot.sv
// demux_slot: one-entry output register for a single demux channel.
// A load always wins over a drain in the same cycle.
//
//   state      | meaning
//   SLOT_EMPTY | no word held, out_valid=0
//   SLOT_FULL  | word held on out_data, out_valid=1
module demux_slot
    import demux_4ch_stream_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SLOT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (load) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (!load && out_ready) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end

    // Data keeps its last value after a drain; only a load replaces it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= load_data;
        end
    end

    assign out_valid = (r_state == SLOT_FULL);
    assign out_data  = r_data;

endmodule

// File: rtl/demux_4ch_stream.sv
// demux_4ch_stream: 1-to-4 registered valid/ready demultiplexer with explicit or
// round-robin targeting. Define DEMUX_4CH_STREAM_CNT_EN for per-channel load counters.
module demux_4ch_stream
    import demux_4ch_stream_pkg::*;
#(
    parameter int DATA_W = 8
)
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [SEL_W-1:0]         sel,
    input  logic                     sel_mode,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready,
    output logic [SEL_W-1:0]         rr_ptr
`ifdef DEMUX_4CH_STREAM_CNT_EN
    ,
    input  logic                     cnt_clr,
    output logic [NUM_CH*8-1:0]      ch_cnt
`endif
);

    ch_idx_t           r_rr_ptr;
    ch_idx_t           w_tgt;
    logic              w_accept;
    logic [NUM_CH-1:0] w_load;

    assign w_tgt    = (sel_mode == MODE_RR) ? r_rr_ptr : sel;
    // A full slot that drains this cycle can take the new word.
    assign in_ready = ~out_valid[w_tgt] | out_ready[w_tgt];
    assign w_accept = in_valid & in_ready;
    assign rr_ptr   = r_rr_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_accept && (sel_mode == MODE_RR)) begin
            r_rr_ptr <= r_rr_ptr + 2'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
        assign w_load[g] = w_accept & (w_tgt == ch_idx_t'(g));

        demux_slot #(.DATA_W(DATA_W)) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (w_load[g]),
            .load_data (in_data),
            .out_ready (out_ready[g]),
            .out_valid (out_valid[g]),
            .out_data  (out_data[g*DATA_W +: DATA_W])
        );
    end

`ifdef DEMUX_4CH_STREAM_CNT_EN
    logic [7:0] r_cnt [NUM_CH];

    // Clear has priority over a coincident load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= 8'd0;
        end else if (cnt_clr) begin
            for (int k = 0; k < NUM_CH; k++) r_cnt[k] <= 8'd0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_load[k]) r_cnt[k] <= r_cnt[k] + 8'd1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_cnt
        assign ch_cnt[g*8 +: 8] = r_cnt[g];
    end
`endif

endmodule

// File: tb/tb_demux_4ch_stream.sv
// Self-checking bench for demux_4ch_stream: directed scenarios plus randomized
// traffic, all compared against a channel-array reference model.
module tb_demux_4ch_stream;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  sel;
    logic        sel_mode;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [1:0]  rr_ptr;
`ifdef DEMUX_4CH_STREAM_CNT_EN
    logic        cnt_clr;
    logic [31:0] ch_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // reference model
    logic [3:0] m_valid;
    logic [7:0] m_data [4];
    int         m_ptr;
    int         m_cnt  [4];

    demux_4ch_stream #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .sel_mode  (sel_mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
`ifdef DEMUX_4CH_STREAM_CNT_EN
        ,
        .cnt_clr   (cnt_clr),
        .ch_cnt    (ch_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=0x%0h expected=0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 4'b0000;
        m_ptr   = 0;
        for (int k = 0; k < 4; k++) begin
            m_data[k] = 8'h00;
            m_cnt[k]  = 0;
        end
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_valid);
        chk("rr_ptr", rr_ptr, m_ptr);
        for (int k = 0; k < 4; k++) chk($sformatf("out_data_ch%0d", k), out_data[k*8 +: 8], m_data[k]);
`ifdef DEMUX_4CH_STREAM_CNT_EN
        for (int k = 0; k < 4; k++) chk($sformatf("ch_cnt_%0d", k), ch_cnt[k*8 +: 8], m_cnt[k]);
`endif
    endtask

    // Called just after a negedge with inputs driven; returns at the next negedge.
    task automatic step();
        int         t;
        bit         rdy;
        bit         acc;
        logic [3:0] nv;
        logic [7:0] nd [4];
        int         np;
        int         nc [4];
        bit         clr;
        #1;
        t   = sel_mode ? m_ptr : int'(sel);
        rdy = !m_valid[t] || out_ready[t];
        acc = in_valid && rdy;
        chk("in_ready", in_ready, rdy);
        clr = 1'b0;
`ifdef DEMUX_4CH_STREAM_CNT_EN
        clr = cnt_clr;
`endif
        nv = m_valid;
        np = (acc && sel_mode) ? (m_ptr + 1) % 4 : m_ptr;
        for (int k = 0; k < 4; k++) begin
            nd[k] = m_data[k];
            nc[k] = clr ? 0 : m_cnt[k];
            if (acc && k == t) begin
                nv[k] = 1'b1;
                nd[k] = in_data;
                if (!clr) nc[k] = (m_cnt[k] + 1) % 256;
            end else if (m_valid[k] && out_ready[k]) begin
                nv[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_valid = nv;
        m_ptr   = np;
        for (int k = 0; k < 4; k++) begin
            m_data[k] = nd[k];
            m_cnt[k]  = nc[k];
        end
        check_outputs();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s, input logic m);
        in_valid = v;
        in_data  = d;
        sel      = s;
        sel_mode = m;
    endtask

    initial begin
        bit         hold;
        rst_n     = 1'b0;
        out_ready = 4'hF;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
`ifdef DEMUX_4CH_STREAM_CNT_EN
        cnt_clr = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 4'b0000);
        chk("reset_rr_ptr", rr_ptr, 2'd0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk("reset_out_data", out_data, 32'h0);
        @(negedge clk);

        // explicit select, one word per channel
        for (int i = 0; i < 4; i++) begin
            logic [7:0] w;
            w = 8'(8'h11 * (i + 1));
            drive(1'b1, w, 2'(i), 1'b0);
            step();
            chk("sel_onehot", out_valid, 4'b0001 << i);
            chk("sel_data", out_data[i*8 +: 8], w);
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        step();

        // round-robin with channel 2 stalled
        out_ready = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 8'(8'hA0 + i), 2'd0, 1'b1);
            step();
            chk("rr_data", out_data[(i%4)*8 +: 8], 8'(8'hA0 + i));
            if (i == 3) chk("rr_wrap", rr_ptr, 2'd0);
        end
        drive(1'b1, 8'hA6, 2'd0, 1'b1);
        #1;
        chk("rr_stall_ready", in_ready, 1'b0);
        step();
        step();
        chk("rr_stall_ptr", rr_ptr, 2'd2);
        chk("rr_stall_hold", out_data[23:16], 8'hA2);
        out_ready = 4'b1111;
        step();
        chk("rr_unstall_data", out_data[23:16], 8'hA6);
        chk("rr_unstall_valid", out_valid[2], 1'b1);
        chk("rr_unstall_ptr", rr_ptr, 2'd3);
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        step();

        // back-to-back on channel 1
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 8'(i), 2'd1, 1'b0);
            #1;
            chk("b2b_ready", in_ready, 1'b1);
            step();
            chk("b2b_data", out_data[15:8], 8'(i));
            chk("b2b_valid", out_valid[1], 1'b1);
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        step();

        // randomized traffic
        hold = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (!hold) begin
                drive($urandom_range(0, 3) != 0, 8'($urandom), 2'($urandom),
                      ($urandom_range(0, 15) == 0) ? ~sel_mode : sel_mode);
            end
            out_ready = 4'($urandom);
`ifdef DEMUX_4CH_STREAM_CNT_EN
            cnt_clr = ($urandom_range(0, 63) == 0);
`endif
            #1;
            hold = in_valid && !in_ready;
            step();
        end
`ifdef DEMUX_4CH_STREAM_CNT_EN
        cnt_clr = 1'b0;
`endif

        // asynchronous reset mid-operation: ch0 and ch3 full, rr_ptr=3
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        out_ready = 4'b1111;
        step();
        step();
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 4'b0110;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'(8'hC0 + i), 2'd0, 1'b1);
            step();
        end
        drive(1'b1, 8'hC3, 2'd3, 1'b0);
        step();
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        step();
        chk("pre_rst_valid", out_valid, 4'b1001);
        chk("pre_rst_ptr", rr_ptr, 2'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 4'b0000);
        chk("async_rst_ptr", rr_ptr, 2'd0);
        chk("async_rst_data", out_data, 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 4'b1111;
        step();

`ifdef DEMUX_4CH_STREAM_CNT_EN
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 8'(i), 2'd0, 1'b0);
            step();
        end
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        chk("cnt_300", ch_cnt[7:0], 8'd44);
        drive(1'b1, 8'h55, 2'd2, 1'b0);
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        drive(1'b0, 8'h00, 2'd0, 1'b0);
        chk("cnt_clr", ch_cnt, 32'h0);
        step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
